// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types and mode constants for master and slave
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_slave_state_t;

  localparam int SPI_DATA_W = 8;

  // Mode 0 on both sides: sample on sclk rise, change on sclk fall
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall pulse detect
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - oversampled mode-0 SPI target with TX shadow and RX strobe
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic sclk_lvl_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .dout(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n),
    .dout(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );

  // Same depth as sclk so the sampled bit lines up with the detected rise
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_slave_state_t  state_q, state_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              shadow_full_q, shadow_full_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic              busy_q, busy_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic              frame_abort_q, frame_abort_d;
  logic              reload;

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    busy_d        = busy_q;
    tx_underrun_d = 1'b0;
    frame_abort_d = 1'b0;
    reload        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = SHIFT;
          reload     = 1'b1;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          busy_d     = 1'b1;
          miso_oe_d  = 1'b1;
        end
      end
      SHIFT: begin
        // cs_n rise takes priority over any sclk edge seen in the same cycle
        if (cs_rise) begin
          state_d       = IDLE;
          frame_abort_d = (bit_cnt_q != '0);
          bit_cnt_d     = '0;
          rx_shift_d    = '0;
          tx_shift_d    = '0;
          busy_d        = 1'b0;
          miso_oe_d     = 1'b0;
          miso_d        = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == '0) begin
            reload = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            miso_d     = tx_shift_d[DATA_W-1];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (reload) begin
      if (shadow_full_q) begin
        tx_shift_d    = shadow_q;
        shadow_full_d = 1'b0;
      end else begin
        tx_shift_d    = '0;
        tx_underrun_d = 1'b1;
      end
      miso_d = tx_shift_d[DATA_W-1];
    end

    // Capture after the copy so a same-cycle load keeps the shadow full
    if (tx_valid && !shadow_full_q) begin
      shadow_d      = tx_data;
      shadow_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      bit_cnt_q     <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      busy_q        <= busy_d;
      tx_underrun_q <= tx_underrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = ~shadow_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// tb/tb_spi_slave_core.sv - directed bench driving a mode-0 SPI master model
module tb_spi_slave_core;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, frame_abort;
  logic [DW-1:0] rx_data;

  spi_slave_core #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .tx_underrun(tx_underrun), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int            rx_cnt = 0;
  int            ur_cnt = 0;
  int            ab_cnt = 0;
  logic [DW-1:0] rxq[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rxq.push_back(rx_data);
    end
    if (tx_underrun) ur_cnt++;
    if (frame_abort) ab_cnt++;
  end

  int div = 4;

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [DW-1:0] b);
    int t = 0;
    while (!tx_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic xfer(input logic [DW-1:0] mo, input int nbits, output logic [DW-1:0] mi);
    mi = '0;
    for (int i = DW - 1; i >= DW - nbits; i--) begin
      mosi = mo[i];
      clks(div);
      sclk = 1'b1;
      mi = {mi[DW-2:0], miso};
      clks(div);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_end();
    clks(div);
    cs_n = 1'b1;
    mosi = 1'b0;
    clks(div + 6);
  endtask

  function automatic logic [31:0] rx_at(input int idx);
    if (idx < rxq.size()) return {24'd0, rxq[idx]};
    return 32'hDEAD;
  endfunction

  task automatic one_frame(input logic [DW-1:0] tx, input logic [DW-1:0] mo, input string tag);
    int            base;
    logic [DW-1:0] got;
    base = rx_cnt;
    load_tx(tx);
    cs_n = 1'b0;
    xfer(mo, DW, got);
    frame_end();
    chk({tag, "_miso"}, {24'd0, got}, {24'd0, tx});
    chk({tag, "_rxcnt"}, rx_cnt - base, 32'd1);
    chk({tag, "_rxdata"}, rx_at(base), {24'd0, mo});
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            rb, ub, ab;
    logic [DW-1:0] g0, g1, g2;
    int            divs[3];
    divs = '{4, 6, 16};

    // Reset state
    clks(3);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_underrun", {31'd0, tx_underrun}, 32'd0);
    chk("rst_abort", {31'd0, frame_abort}, 32'd0);
    rst = 1'b0;
    clks(4);

    // Single byte: tx 0xA5, mosi 0x3C
    rb = rx_cnt;
    ub = ur_cnt;
    load_tx(8'hA5);
    chk("t1_ready_low", {31'd0, tx_ready}, 32'd0);
    cs_n = 1'b0;
    clks(5);
    chk("t1_ready_back", {31'd0, tx_ready}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_miso_oe", {31'd0, miso_oe}, 32'd1);
    chk("t1_msb", {31'd0, miso}, 32'd1);
    chk("t1_no_underrun", ur_cnt - ub, 32'd0);
    xfer(8'h3C, DW, g0);
    frame_end();
    chk("t1_miso", {24'd0, g0}, 32'hA5);
    chk("t1_rxcnt", rx_cnt - rb, 32'd1);
    chk("t1_rxq", rx_at(rb), 32'h3C);
    chk("t1_rx_data", {24'd0, rx_data}, 32'h3C);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    chk("t1_idle_oe", {31'd0, miso_oe}, 32'd0);

    // Three-byte burst with just-in-time loads
    rb = rx_cnt;
    ub = ur_cnt;
    load_tx(8'h11);
    cs_n = 1'b0;
    fork
      begin
        xfer(8'hF0, DW, g0);
        xfer(8'h0F, DW, g1);
        xfer(8'h81, DW, g2);
      end
      begin
        load_tx(8'h22);
        load_tx(8'h33);
      end
    join
    chk("burst_no_underrun", ur_cnt - ub, 32'd0);
    frame_end();
    chk("burst_miso0", {24'd0, g0}, 32'h11);
    chk("burst_miso1", {24'd0, g1}, 32'h22);
    chk("burst_miso2", {24'd0, g2}, 32'h33);
    chk("burst_rxcnt", rx_cnt - rb, 32'd3);
    chk("burst_rx0", rx_at(rb), 32'hF0);
    chk("burst_rx1", rx_at(rb + 1), 32'h0F);
    chk("burst_rx2", rx_at(rb + 2), 32'h81);

    // Underrun: nothing loaded; another pulse follows at the trailing byte boundary
    ub = ur_cnt;
    rb = rx_cnt;
    cs_n = 1'b0;
    clks(5);
    chk("ur_at_cs_fall", ur_cnt - ub, 32'd1);
    xfer(8'h55, DW, g0);
    frame_end();
    chk("ur_total", ur_cnt - ub, 32'd2);
    chk("ur_miso", {24'd0, g0}, 32'h00);
    chk("ur_rxdata", rx_at(rb), 32'h55);

    // Abort after 5 bits
    load_tx(8'h77);
    rb = rx_cnt;
    ab = ab_cnt;
    cs_n = 1'b0;
    xfer(8'hB4, 5, g0);
    frame_end();
    chk("abort_pulse", ab_cnt - ab, 32'd1);
    chk("abort_no_rx", rx_cnt - rb, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_partial_miso", {24'd0, g0}, 32'h0E);
    one_frame(8'h9A, 8'h6B, "after_abort");

    // Asynchronous reset after 3 bits
    load_tx(8'h44);
    cs_n = 1'b0;
    xfer(8'hE7, 3, g0);
    clks(1);
    rst = 1'b1;
    #1;
    chk("mrst_miso", {31'd0, miso}, 32'd0);
    chk("mrst_oe", {31'd0, miso_oe}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_ready", {31'd0, tx_ready}, 32'd1);
    chk("mrst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("mrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    cs_n = 1'b1;
    mosi = 1'b0;
    clks(4);
    rst = 1'b0;
    clks(4);
    one_frame(8'hC3, 8'h9E, "post_rst");

    // Clock-divider sweep with random bytes
    foreach (divs[k]) begin
      div = divs[k];
      repeat (3) one_frame(DW'($urandom), DW'($urandom), $sformatf("sweep_div%0d", div));
    end

    // sclk toggling with cs_n high must be ignored
    div = 4;
    rb = rx_cnt;
    ub = ur_cnt;
    repeat (16) begin
      clks(4);
      sclk = ~sclk;
    end
    clks(6);
    chk("idle_sclk_busy", {31'd0, busy}, 32'd0);
    chk("idle_sclk_oe", {31'd0, miso_oe}, 32'd0);
    chk("idle_sclk_rx", rx_cnt - rb, 32'd0);
    chk("idle_sclk_ur", ur_cnt - ub, 32'd0);
    one_frame(8'h5A, 8'hA5, "post_idle_sclk");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
